cyber_press_shaper: RTL

//  Downstream of the cyber-player comparator: turns its raw per-cycle "SW > LFSR" level into

---
 rtl/cyber_press_shaper.sv | 93 +++++++++
 1 files changed

// File: rtl/cyber_press_shaper.sv
// Shapes the cyber-player comparator level into spaced 1-cycle button presses.
// Define CYBER_PRESS_STATS_EN to build the saturating press tally; otherwise press_count is 0.
module cyber_press_shaper #(
  parameter int unsigned HOLDOFF = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             press_raw,
  input  logic             clr_count,
  output logic             press_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {StIdle, StFire, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       pulse_q, pulse_d;
  logic       busy_q, busy_d;

  // press_raw is only looked at in StIdle, so an unknown value during HOLD cannot leak.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (!enable) begin
      state_d = StIdle;
      hold_d  = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (press_raw) state_d = StFire;
        end
        StFire: begin
          state_d = StHold;
          hold_d  = 8'(HOLDOFF - 1);
        end
        StHold: begin
          if (hold_q == 8'd0) state_d = StIdle;
          else                hold_d  = hold_q - 8'd1;
        end
        default: state_d = StIdle;
      endcase
    end
    pulse_d = (state_d == StFire);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hold_q  <= 8'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign press_pulse = pulse_q;
  assign busy        = busy_q;

`ifdef CYBER_PRESS_STATS_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over a coincident press; the tally sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (pulse_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign press_count = count_q;
`else
  logic unused_clr_count;
  assign unused_clr_count = clr_count;
  assign press_count      = '0;
`endif

endmodule
